// File: rtl/pbs_cmd_issuer.sv
// Queues host PBS commands and drives them one at a time through the engine's start/done level handshake.
// Optional watchdog per command is compiled in with `define TFHE_PBS_TIMEOUT_EN.
module pbs_cmd_issuer #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH         = 4,
  parameter logic [31:0] TIMEOUT_CYCLES     = 32'hFFFF_FFFF
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       cmd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       cmd_len,
  output logic                                start_pbs,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       host_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       host_wr_len,
  input  logic                                pbs_busy,
  input  logic                                pbs_done,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       host_rd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       host_rd_len,
  output logic                                res_valid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       res_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       res_len,
  output logic [15:0]                         done_cnt,
  output logic                                irq_done,
  input  logic                                irq_clr,
  output logic [$clog2(FIFO_DEPTH):0]         q_level,
  output logic                                err_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam int W = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       addr_mem_q [FIFO_DEPTH];
  logic [W-1:0]       addr_mem_d [FIFO_DEPTH];
  logic [W-1:0]       len_mem_q  [FIFO_DEPTH];
  logic [W-1:0]       len_mem_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               start_q, start_d;
  logic [W-1:0]       wr_addr_q, wr_addr_d;
  logic [W-1:0]       wr_len_q, wr_len_d;
  logic               res_valid_q, res_valid_d;
  logic [W-1:0]       res_addr_q, res_addr_d;
  logic [W-1:0]       res_len_q, res_len_d;
  logic [15:0]        done_cnt_q, done_cnt_d;
  logic               irq_q, irq_d;
  logic               push, pop, complete;
  logic               unused_sig;

`ifdef TFHE_PBS_TIMEOUT_EN
  logic [31:0]        wd_q, wd_d;
  logic               err_q, err_d;
  logic               expire;
`endif

  // Busy is informational only; the engine is sequenced purely by start/done.
  assign unused_sig = pbs_busy ^ TIMEOUT_CYCLES[0];

  always_comb begin
    state_d     = state_q;
    addr_mem_d  = addr_mem_q;
    len_mem_d   = len_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    lvl_d       = lvl_q;
    start_d     = start_q;
    wr_addr_d   = wr_addr_q;
    wr_len_d    = wr_len_q;
    res_valid_d = 1'b0;
    res_addr_d  = res_addr_q;
    res_len_d   = res_len_q;
    done_cnt_d  = done_cnt_q;
    irq_d       = irq_q;
    pop         = 1'b0;
    complete    = 1'b0;
    push        = cmd_valid && cmd_ready_q;
`ifdef TFHE_PBS_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = err_q;
    expire      = 1'b0;
`endif

    if (push) begin
      addr_mem_d[wr_ptr_q] = cmd_addr;
      len_mem_d[wr_ptr_q]  = cmd_len;
    end

    case (state_q)
      S_IDLE: begin
        if (lvl_q != '0) begin
          pop       = 1'b1;
          wr_addr_d = addr_mem_q[rd_ptr_q];
          wr_len_d  = len_mem_q[rd_ptr_q];
          start_d   = 1'b1;
          state_d   = S_ISSUE;
`ifdef TFHE_PBS_TIMEOUT_EN
          wd_d      = '0;
`endif
        end
      end
      S_ISSUE: begin
        if (pbs_done) begin
          complete    = 1'b1;
          start_d     = 1'b0;
          res_addr_d  = host_rd_addr;
          res_len_d   = host_rd_len;
          res_valid_d = 1'b1;
          done_cnt_d  = done_cnt_q + 16'd1;
          state_d     = S_GAP;
        end
`ifdef TFHE_PBS_TIMEOUT_EN
        else if (wd_q + 32'd1 == TIMEOUT_CYCLES) begin
          expire  = 1'b1;
          start_d = 1'b0;
          state_d = S_GAP;
        end else begin
          wd_d = wd_q + 32'd1;
        end
`endif
      end
      // One low cycle lets the engine re-arm its start edge detector.
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    lvl_d       = lvl_q + LVL_W'(push) - LVL_W'(pop);
    cmd_ready_d = (lvl_d != FULL_LVL);

    if (irq_clr)  irq_d = 1'b0;
    if (complete) irq_d = 1'b1;
`ifdef TFHE_PBS_TIMEOUT_EN
    if (irq_clr) err_d = 1'b0;
    if (expire)  err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lvl_q       <= '0;
      cmd_ready_q <= 1'b1;
      start_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_len_q    <= '0;
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      res_len_q   <= '0;
      done_cnt_q  <= '0;
      irq_q       <= 1'b0;
`ifdef TFHE_PBS_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lvl_q       <= lvl_d;
      cmd_ready_q <= cmd_ready_d;
      start_q     <= start_d;
      wr_addr_q   <= wr_addr_d;
      wr_len_q    <= wr_len_d;
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
      res_len_q   <= res_len_d;
      done_cnt_q  <= done_cnt_d;
      irq_q       <= irq_d;
`ifdef TFHE_PBS_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  // Queue storage carries only data; occupancy and pointers gate its validity.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    len_mem_q  <= len_mem_d;
  end

  assign cmd_ready    = cmd_ready_q;
  assign start_pbs    = start_q;
  assign host_wr_addr = wr_addr_q;
  assign host_wr_len  = wr_len_q;
  assign res_valid    = res_valid_q;
  assign res_addr     = res_addr_q;
  assign res_len      = res_len_q;
  assign done_cnt     = done_cnt_q;
  assign irq_done     = irq_q;
  assign q_level      = lvl_q;
`ifdef TFHE_PBS_TIMEOUT_EN
  assign err_timeout  = err_q;
`else
  assign err_timeout  = 1'b0;
`endif

endmodule
